// File: rtl/sample_iter4_tx_pkg.sv
// Shared raster definitions: iterator states, lane count and subsample step decode.
package sample_iter4_tx_pkg;

    localparam int LANES = 4;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } state_t;

    // One-hot subsample select to step size in fixed point; highest set bit
    // wins, and an all-zero select falls back to a full-pixel step.
    function automatic int unsigned step_decode(input logic [3:0] sub, input int unsigned radix);
        int unsigned step;
        if (sub[3])      step = 32'd1 << radix;
        else if (sub[2]) step = 32'd1 << (radix - 1);
        else if (sub[1]) step = 32'd1 << (radix - 2);
        else if (sub[0]) step = 32'd1 << (radix - 3);
        else             step = 32'd1 << radix;
        return step;
    endfunction

endpackage

// File: rtl/sample_iter4_tx.sv
// Four-wide sample iterator: walks a triangle bounding box row-major at the
// latched subsample pitch, emitting four adjacent sample positions per cycle.
//
// state | meaning
// WAIT  | idle, halt_RnnnnL=1, accepts a triangle when validTri_R13H=1
// TEST  | emitting one four-lane group per cycle until the box is covered
module sample_iter4_tx
    import sample_iter4_tx_pkg::*;
#(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S   [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S   [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S   [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2][LANES],
    output logic        [LANES-1:0]  validSamp_R14H
);

    // Extra headroom so cx + 4s can never wrap before the compare.
    localparam int W3 = SIGFIG + 3;

    state_t                   r_state;
    logic signed [W3-1:0]     r_cx;
    logic signed [W3-1:0]     r_cy;
    logic signed [W3-1:0]     r_llx;
    logic signed [W3-1:0]     r_urx;
    logic signed [W3-1:0]     r_ury;
    logic signed [W3-1:0]     r_step;
    logic signed [SIGFIG-1:0] r_tri    [VERTS][AXIS];
    logic        [SIGFIG-1:0] r_color  [COLORS];
    logic signed [SIGFIG-1:0] r_sample [2][LANES];
    logic        [LANES-1:0]  r_valid;

    logic signed [W3-1:0]     w_step_in;
    logic signed [W3-1:0]     w_lane_x [LANES];
    logic        [LANES-1:0]  w_lane_ok;
    logic signed [W3-1:0]     w_next_x;
    logic signed [W3-1:0]     w_next_y;
    logic                     w_next_x_ok;
    logic                     w_next_y_ok;

    assign w_step_in = W3'(step_decode(subSample_RnnnnU, RADIX));

    // Lane positions and in-box tests for the current cursor.
    always_comb begin
        w_lane_x[0] = r_cx;
        w_lane_x[1] = r_cx + r_step;
        w_lane_x[2] = r_cx + (r_step <<< 1);
        w_lane_x[3] = r_cx + r_step + (r_step <<< 1);
        w_lane_ok   = '0;
        for (int k = 0; k < LANES; k++) begin
            w_lane_ok[k] = (w_lane_x[k] <= r_urx);
        end
        w_next_x    = r_cx + (r_step <<< 2);
        w_next_y    = r_cy + r_step;
        w_next_x_ok = (w_next_x <= r_urx);
        w_next_y_ok = (w_next_y <= r_ury);
    end

    // Iterator FSM with cursor, latched triangle and registered sample outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WAIT;
            r_cx    <= '0;
            r_cy    <= '0;
            r_llx   <= '0;
            r_urx   <= '0;
            r_ury   <= '0;
            r_step  <= '0;
            r_valid <= '0;
            for (int v = 0; v < VERTS; v++) begin
                for (int a = 0; a < AXIS; a++) begin
                    r_tri[v][a] <= '0;
                end
            end
            for (int c = 0; c < COLORS; c++) begin
                r_color[c] <= '0;
            end
            for (int k = 0; k < LANES; k++) begin
                r_sample[0][k] <= '0;
                r_sample[1][k] <= '0;
            end
        end else begin
            case (r_state)
                WAIT: begin
                    r_valid <= '0;
                    if (validTri_R13H) begin
                        r_tri   <= tri_R13S;
                        r_color <= color_R13U;
                        r_llx   <= W3'(box_R13S[0][0]);
                        r_urx   <= W3'(box_R13S[1][0]);
                        r_ury   <= W3'(box_R13S[1][1]);
                        r_cx    <= W3'(box_R13S[0][0]);
                        r_cy    <= W3'(box_R13S[0][1]);
                        r_step  <= w_step_in;
                        r_state <= TEST;
                    end
                end
                TEST: begin
                    for (int k = 0; k < LANES; k++) begin
                        r_sample[0][k] <= w_lane_x[k][SIGFIG-1:0];
                        r_sample[1][k] <= r_cy[SIGFIG-1:0];
                    end
                    r_valid <= w_lane_ok;
                    if (w_next_x_ok) begin
                        r_cx <= w_next_x;
                    end else if (w_next_y_ok) begin
                        r_cx <= r_llx;
                        r_cy <= w_next_y;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    assign halt_RnnnnL    = (r_state == WAIT);
    assign tri_R14S       = r_tri;
    assign color_R14U     = r_color;
    assign sample_R14S    = r_sample;
    assign validSamp_R14H = r_valid;

endmodule

// File: tb/tb_sample_iter4_tx.sv
// Directed bench for sample_iter4_tx with hand-computed expected groups.
module tb_sample_iter4_tx;

    localparam int SIGFIG = 24;

    logic                     clk;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_R13S   [3][3];
    logic        [SIGFIG-1:0] color_R13U [3];
    logic signed [SIGFIG-1:0] box_R13S   [2][2];
    logic                     validTri_R13H;
    logic        [3:0]        subSample_RnnnnU;
    logic                     halt_RnnnnL;
    logic signed [SIGFIG-1:0] tri_R14S   [3][3];
    logic        [SIGFIG-1:0] color_R14U [3];
    logic signed [SIGFIG-1:0] sample_R14S [2][4];
    logic        [3:0]        validSamp_R14H;

    int n_checks;
    int n_fail;

    sample_iter4_tx dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnL      (halt_RnnnnL),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_box(input int llx, input int lly, input int urx, input int ury);
        box_R13S[0][0] = 24'(llx);
        box_R13S[0][1] = 24'(lly);
        box_R13S[1][0] = 24'(urx);
        box_R13S[1][1] = 24'(ury);
    endtask

    // Lane bit k of vmask is lane k (lane 0 leftmost in the group).
    task automatic check_group(input string tag, input int x0, input int step, input int y,
                               input logic [3:0] vmask);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("%s_x%0d", tag, k), 32'(sample_R14S[0][k]), 32'(x0 + k * step));
            check_val($sformatf("%s_y%0d", tag, k), 32'(sample_R14S[1][k]), 32'(y));
        end
        check_val($sformatf("%s_valid", tag), 32'(validSamp_R14H), 32'(vmask));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 0, 0);
        for (int v = 0; v < 3; v++) begin
            color_R13U[v] = 24'(100 + v);
            for (int a = 0; a < 3; a++) tri_R13S[v][a] = 24'(10 * v + a + 1);
        end

        // Reset state
        #2;
        check_val("rst_halt", 32'(halt_RnnnnL), 32'd1);
        check_val("rst_valid", 32'(validSamp_R14H), 32'd0);
        check_val("rst_sx0", 32'(sample_R14S[0][0]), 32'd0);
        check_val("rst_sy3", 32'(sample_R14S[1][3]), 32'd0);
        check_val("rst_tri", 32'(tri_R14S[1][2]), 32'd0);
        check_val("rst_color", 32'(color_R14U[2]), 32'd0);
        tick();
        // Accept requested on the releasing edge is refused: reset still low here.
        validTri_R13H = 1'b1;
        tick();
        check_val("rst_wins_halt", 32'(halt_RnnnnL), 32'd1);
        validTri_R13H = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_val("idle_halt", 32'(halt_RnnnnL), 32'd1);
        check_val("idle_valid", 32'(validSamp_R14H), 32'd0);
        check_val("idle_sx1", 32'(sample_R14S[0][1]), 32'd0);

        // MSAA1, box (0,0)-(3072,1024): two full groups
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 3072, 1024);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        subSample_RnnnnU = 4'b0001;  // must not affect the in-flight triangle
        check_val("t1_halt_busy", 32'(halt_RnnnnL), 32'd0);
        check_val("t1_tri", 32'(tri_R14S[2][1]), 32'd22);
        check_val("t1_color", 32'(color_R14U[1]), 32'd101);
        tick();
        check_group("t1_g1", 0, 1024, 0, 4'b1111);
        check_val("t1_g1_halt", 32'(halt_RnnnnL), 32'd0);
        tick();
        check_group("t1_g2", 0, 1024, 1024, 4'b1111);
        check_val("t1_g2_halt", 32'(halt_RnnnnL), 32'd1);
        tick();
        check_val("t1_after_valid", 32'(validSamp_R14H), 32'd0);
        check_val("t1_after_tri", 32'(tri_R14S[0][0]), 32'd1);

        // MSAA1, box (0,0)-(4096,0): second group partially valid
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 4096, 0);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        check_group("t2_g1", 0, 1024, 0, 4'b1111);
        tick();
        check_group("t2_g2", 4096, 1024, 0, 4'b0001);
        check_val("t2_halt", 32'(halt_RnnnnL), 32'd1);
        tick();

        // MSAA4 (s=512), degenerate box at (512,512)
        subSample_RnnnnU = 4'b0100;
        set_box(512, 512, 512, 512);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        check_group("t3_g1", 512, 512, 512, 4'b0001);
        check_val("t3_halt", 32'(halt_RnnnnL), 32'd1);
        tick();
        check_val("t3_after_valid", 32'(validSamp_R14H), 32'd0);

        // validTri held high through a 3-group triangle (one column, three rows)
        subSample_RnnnnU = 4'b1000;
        set_box(0, 0, 0, 2048);
        validTri_R13H = 1'b1;
        tick();
        tick();
        check_group("t4_g1", 0, 1024, 0, 4'b0001);
        check_val("t4_g1_halt", 32'(halt_RnnnnL), 32'd0);
        tick();
        check_group("t4_g2", 0, 1024, 1024, 4'b0001);
        tick();
        check_group("t4_g3", 0, 1024, 2048, 4'b0001);
        check_val("t4_g3_halt", 32'(halt_RnnnnL), 32'd1);
        set_box(0, 5120, 0, 5120);   // next triangle presented once halt is high
        tri_R13S[0][0] = 24'd77;
        tick();
        check_val("t4_bubble_valid", 32'(validSamp_R14H), 32'd0);
        check_val("t4_second_accepted", 32'(halt_RnnnnL), 32'd0);
        check_val("t4_second_tri", 32'(tri_R14S[0][0]), 32'd77);
        validTri_R13H = 1'b0;
        tick();
        check_group("t4_b_g1", 0, 1024, 5120, 4'b0001);
        check_val("t4_b_halt", 32'(halt_RnnnnL), 32'd1);
        tick();

        // Reset pulsed during the second group of a 4-group box
        set_box(0, 0, 0, 3072);
        validTri_R13H = 1'b1;
        tick();
        validTri_R13H = 1'b0;
        tick();
        check_group("t5_g1", 0, 1024, 0, 4'b0001);
        tick();
        check_group("t5_g2", 0, 1024, 1024, 4'b0001);
        #1;
        rst = 1'b0;
        #1;
        check_val("t5_rst_valid", 32'(validSamp_R14H), 32'd0);
        check_val("t5_rst_halt", 32'(halt_RnnnnL), 32'd1);
        check_val("t5_rst_sy", 32'(sample_R14S[1][0]), 32'd0);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val($sformatf("t5_post_valid%0d", i), 32'(validSamp_R14H), 32'd0);
            check_val($sformatf("t5_post_halt%0d", i), 32'(halt_RnnnnL), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_iter4_tx.md
# sample_iter4_tx

Four-wide sample iterator for the raster pipeline. It accepts one bounded triangle per handshake on the R13 boundary. It walks the bounding box in row-major order at the current subsample pitch and each cycle emits four horizontally adjacent sample positions with per-lane valid bits. Its R14 outputs feed the four-lane jitter-hash stage directly; that stage is non-stalling, so this block is the only point of back-pressure toward setup.

## Interface
- SIGFIG, 24, fixed-point word width
- RADIX, 10, fractional bits; one pixel = 1<<RADIX
- VERTS, 3, vertices per triangle
- AXIS, 3, coordinates per vertex
- COLORS, 3, color channels
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle
- color_R13U  in  [SIGFIG-1:0] [COLORS]  color
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y
- validTri_R13H  in  1  triangle/box valid
- subSample_RnnnnU  in  4  one-hot subsample pitch select
- halt_RnnnnL  out  1  1 = block can accept a triangle this cycle
- tri_R14S, color_R14U  out  as inputs  latched triangle and color
- sample_R14S  out  signed [SIGFIG-1:0] [2][4]  [axis][lane]
- validSamp_R14H  out  1 [4]  per-lane valid

## Operation
- Step s from subSample_RnnnnU:
  - [3] → 1<<RADIX
  - [2] → 1<<(RADIX-1)
  - [1] → 1<<(RADIX-2)
  - [0] → 1<<(RADIX-3)
- s is latched at accept; a change in subSample_RnnnnU mid-triangle has no effect until the next accept.
- FSM has two states, WAIT and TEST.
- halt_RnnnnL = (state == WAIT), decoded combinationally from the state register.
- WAIT:
  - validTri_R13H=1 → latch tri, color, box, and s; set cursor (cx,cy) = lower-left; go to TEST.
  - Otherwise hold. validSamp_R14H stays all 0.
- TEST, each cycle:
  - Register the group: sample_R14S[0][k] = cx + k·s, sample_R14S[1][k] = cy.
  - validSamp_R14H[k] = (cx + k·s ≤ ur_x).
  - Invalid lanes still carry their computed coordinate.
- Cursor advance (TEST):
  - If cx + 4s ≤ ur_x → cx += 4s.
  - Else if cy + s ≤ ur_y → cx = ll_x, cy += s.
  - Else (last group) → go to WAIT.
- validTri_R13H in TEST is ignored. Upstream holds its data while halt_RnnnnL = 0.
- Arithmetic:
  - All adds and compares use SIGFIG+3-bit signed values, so cx + 4s never wraps.
  - Box corners are assumed aligned to s by setup; no alignment is performed here.
- Degenerate box (ll == ur) → exactly one group: lane 0 valid, lanes 1–3 invalid; then WAIT.
- tri_R14S and color_R14U hold the latched values for the whole TEST period and afterwards.

## Timing
- Accept at edge N → first group on the outputs after edge N+1.
- A box of G groups occupies TEST for G cycles.
- halt_RnnnnL returns to 1 in the cycle after the last group is registered. The next accept therefore costs one bubble cycle between triangles.
- Reset values:
  - state = WAIT, so halt_RnnnnL = 1
  - all sample_R14S, tri_R14S, color_R14U = 0
  - validSamp_R14H = 0
- Reset asserted mid-TEST:
  - Outputs clear and state goes to WAIT immediately (asynchronously).
  - The in-flight triangle is dropped.
  - After release, no valid lane appears until a new accept.
- Simultaneous accept and reset release on the same edge: reset wins; the triangle is not accepted.

## Structure
- Shared raster package holds:
  - the state enum {WAIT, TEST}
  - the step-decode function (subSample → s)
  - the lane count constant LANES = 4
- No sub-module. The datapath (cursor, four adders, four comparators) and the FSM live in one module of roughly 200 lines.

## Test plan
All scenarios use RADIX=10 and SIGFIG=24.
- Reset → halt_RnnnnL=1, all validSamp_R14H=0, sample_R14S=0; release with no triangle → outputs unchanged.
- MSAA1, box (0,0)-(3072,1024):
  - group 1: x = 0/1024/2048/3072, y = 0, valid 1111
  - group 2: same x, y = 1024, valid 1111
  - then halt_RnnnnL=1 one cycle later
- MSAA1, box (0,0)-(4096,0):
  - group 1: x = 0..3072, valid 1111
  - group 2: x = 4096/5120/6144/7168, valid 1000
- MSAA4 (s=512), box (512,512)-(512,512) → single group at x = 512/1024/1536/2048, y = 512, valid 1000.
- validTri_R13H held high through a 3-group triangle → the second triangle is accepted only in the cycle where halt_RnnnnL=1; exactly 3 groups are emitted for the first triangle.
- Reset pulsed during the second group of a 4-group box → validSamp_R14H goes to 0 immediately and halt_RnnnnL=1; no further valid lanes appear until a new accept.
